// File: rtl/sdarb_pkg.sv
// Shared types and sizing for the SDRAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdarb_pkg;

  // Ownership of the Avalon master port.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } gnt_e;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  // Per-grant accept counter; covers a quota of up to 255.
  localparam int QCNT_W = 8;

  // Outstanding read counter; covers a limit of up to 31.
  localparam int OCNT_W = 5;

endpackage

// File: rtl/sdarb_credit_counter.sv
// Outstanding-read tracker: +1 per accepted read, -1 per returned word, full flag.
// Latency: count updates on the clock edge after inc/dec.
// Backpressure: none; a return with nothing outstanding is dropped and flagged sticky.
module sdarb_credit_counter
  import sdarb_pkg::*;
#(
  parameter int MAX = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              dec,
  output logic [OCNT_W-1:0] count,
  output logic              full,
  output logic              dec_ok,
  output logic              err
);

  // A return only counts when something is actually outstanding.
  always_comb begin
    dec_ok = dec & (count != '0);
    full   = (count >= OCNT_W'(MAX));
  end

  // Up/down count; simultaneous inc and valid dec cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (dec && (count == '0)) begin
        err <= 1'b1;
      end
      case ({inc, dec_ok})
        2'b10:   count <= count + OCNT_W'(1);
        2'b01:   count <= count - OCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM Avalon-MM master between a read stream and a write stream with per-grant quota.
// Latency: command one cycle after request from idle; read data one cycle after readdatavalid.
// Backpressure: sdwaitrequest holds the granted command; reads stall at MAX_OUTSTANDING. SDARB_STATS_EN builds stat counters.
module sdram_port_arbiter
  import sdarb_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_OUTSTANDING = 16,
  parameter int GRANT_QUOTA     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sdaddress,
  output logic              sdread,
  output logic              sdwrite,
  output logic [DATA_W-1:0] sdwritedata,
  input  logic [DATA_W-1:0] sdreaddata,
  input  logic              sdreaddatavalid,
  input  logic              sdwaitrequest,
  output logic [4:0]        rd_outstanding,
  output logic              idle,
  output logic              err_unexpected,
  output logic [31:0]       stat_rd_count,
  output logic [31:0]       stat_wr_count,
  output logic [31:0]       stat_wait_cycles
);

  localparam logic [QCNT_W-1:0] QUOTA = QCNT_W'(GRANT_QUOTA);

  gnt_e              gnt, gnt_nxt;
  gnt_e              last_gnt;
  logic [QCNT_W-1:0] qcnt, qcnt_sum;
  logic              credit, cnt_full, ret_ok;
  logic              rd_elig, wr_elig;
  logic              rd_acc, wr_acc, quota_hit;

  sdarb_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (rd_acc),
    .dec     (sdreaddatavalid),
    .count   (rd_outstanding),
    .full    (cnt_full),
    .dec_ok  (ret_ok),
    .err     (err_unexpected)
  );

  // Bus command path: purely combinational from the grant register.
  always_comb begin
    credit      = ~cnt_full;
    rd_elig     = rd_req & credit;
    wr_elig     = wr_req;
    sdread      = (gnt == RD) & rd_elig;
    sdwrite     = (gnt == WR) & wr_req;
    rd_acc      = sdread & ~sdwaitrequest;
    wr_acc      = sdwrite & ~sdwaitrequest;
    rd_ack      = rd_acc;
    wr_ack      = wr_acc;
    sdaddress   = '0;
    sdwritedata = '0;
    if (gnt == RD) begin
      sdaddress = rd_addr;
    end else if (gnt == WR) begin
      sdaddress   = wr_addr;
      sdwritedata = wr_data;
    end
    idle = reset_n & (gnt == NONE) & (rd_outstanding == '0) & ~rd_req & ~wr_req;
  end

  // Accepts within the current grant including this cycle, saturating at the quota.
  always_comb begin
    qcnt_sum = qcnt;
    if ((rd_acc | wr_acc) && (qcnt != QUOTA)) begin
      qcnt_sum = qcnt + QCNT_W'(1);
    end
    quota_hit = (qcnt_sum == QUOTA);
  end

  // Next grant; leaves RD/WR only when no command is left pending unaccepted.
  always_comb begin
    gnt_nxt = gnt;
    case (gnt)
      NONE: begin
        if (rd_elig && wr_elig) begin
          gnt_nxt = (last_gnt == RD) ? WR : RD;
        end else if (rd_elig) begin
          gnt_nxt = RD;
        end else if (wr_elig) begin
          gnt_nxt = WR;
        end
      end
      RD: begin
        if (rd_acc || !rd_elig) begin
          if (quota_hit && wr_elig) begin
            gnt_nxt = WR;
          end else if (!rd_elig) begin
            gnt_nxt = wr_elig ? WR : NONE;
          end
        end
      end
      WR: begin
        if (wr_acc || !wr_req) begin
          if (quota_hit && rd_elig) begin
            gnt_nxt = RD;
          end else if (!wr_req) begin
            gnt_nxt = rd_elig ? RD : NONE;
          end
        end
      end
      default: gnt_nxt = NONE;
    endcase
  end

  // Grant, last-served owner and per-grant accept count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= NONE;
      last_gnt <= WR;
      qcnt     <= '0;
    end else begin
      gnt <= gnt_nxt;
      if (gnt_nxt != NONE) begin
        last_gnt <= gnt_nxt;
      end
      qcnt <= (gnt_nxt != gnt) ? '0 : qcnt_sum;
    end
  end

  // Read return: one-cycle registered copy; stray words are suppressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= sdreaddata;
      rd_valid <= ret_ok;
    end
  end

`ifdef SDARB_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd_count    <= '0;
      stat_wr_count    <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (rd_acc) begin
        stat_rd_count <= stat_rd_count + 32'd1;
      end
      if (wr_acc) begin
        stat_wr_count <= stat_wr_count + 32'd1;
      end
      if ((sdread | sdwrite) & sdwaitrequest) begin
        stat_wait_cycles <= stat_wait_cycles + 32'd1;
      end
    end
  end
`else
  assign stat_rd_count    = '0;
  assign stat_wr_count    = '0;
  assign stat_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: reset, credit limit, quota, hold, simultaneous events, mid-op reset.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: sdwaitrequest and sdreaddatavalid driven by the bench as the Avalon slave.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req, wr_req, rd_ack, wr_ack, rd_valid;
  logic [23:0] rd_addr, wr_addr, sdaddress;
  logic [31:0] wr_data, rd_data, sdwritedata, sdreaddata;
  logic        sdread, sdwrite, sdreaddatavalid, sdwaitrequest;
  logic [4:0]  rd_outstanding;
  logic        idle, err_unexpected;
  logic [31:0] stat_rd_count, stat_wr_count, stat_wait_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_ack           (rd_ack),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_ack           (wr_ack),
    .sdaddress        (sdaddress),
    .sdread           (sdread),
    .sdwrite          (sdwrite),
    .sdwritedata      (sdwritedata),
    .sdreaddata       (sdreaddata),
    .sdreaddatavalid  (sdreaddatavalid),
    .sdwaitrequest    (sdwaitrequest),
    .rd_outstanding   (rd_outstanding),
    .idle             (idle),
    .err_unexpected   (err_unexpected),
    .stat_rd_count    (stat_rd_count),
    .stat_wr_count    (stat_wr_count),
    .stat_wait_cycles (stat_wait_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the drive point just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return one word from the slave and check it appears one cycle later.
  task automatic ret_word(input logic [31:0] d);
    sdreaddatavalid = 1'b1;
    sdreaddata      = d;
    step();
    sdreaddatavalid = 1'b0;
    sdreaddata      = '0;
    @(negedge clk);
    check("ret_vld", 64'(rd_valid), 64'd1);
    check("ret_dat", 64'(rd_data), 64'(d));
    step();
  endtask

  task automatic drain(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      ret_word(base + 32'(i));
    end
    check("drain_out", 64'(rd_outstanding), 64'd0);
    check("drain_err", 64'(err_unexpected), 64'd0);
  endtask

  initial begin
    int   acks, nops, both;
    logic got;
    logic [1:0] exp_op;

    // Reset with random inputs: every output must be low.
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rd_req          = 1'($urandom_range(0, 1));
      wr_req          = 1'($urandom_range(0, 1));
      rd_addr         = 24'($urandom);
      wr_addr         = 24'($urandom);
      wr_data         = $urandom;
      sdreaddata      = $urandom;
      sdreaddatavalid = 1'($urandom_range(0, 1));
      sdwaitrequest   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_cmd", {62'd0, sdread, sdwrite}, 64'd0);
      check("rst_bus", {8'd0, sdaddress, sdwritedata}, 64'd0);
      check("rst_misc", {56'd0, rd_ack, wr_ack, rd_valid, rd_outstanding}, 64'd0);
      check("rst_flags", {62'd0, idle, err_unexpected}, 64'd0);
      check("rst_rdata", 64'(rd_data), 64'd0);
    end
    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    sdreaddata = '0; sdreaddatavalid = 0; sdwaitrequest = 0;
    #2 reset_n = 1'b1;
    step();
    @(negedge clk);
    check("idle_after_rst", 64'(idle), 64'd1);
    step();

    // Credit limit: 16 accepts then stall; one return frees exactly one more.
    rd_req = 1'b1; rd_addr = 24'h000100; acks = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      got = rd_ack;
      if (got) begin
        check("crd_addr", 64'(sdaddress), 64'(24'h000100 + 24'(4 * acks)));
        acks++;
      end
      step();
      if (got) rd_addr = 24'h000100 + 24'(4 * acks);
    end
    @(negedge clk);
    check("crd_acks", 64'(acks), 64'd16);
    check("crd_sdread", 64'(sdread), 64'd0);
    check("crd_out16", 64'(rd_outstanding), 64'd16);
    step();
    sdreaddatavalid = 1'b1; sdreaddata = 32'hA5A50001;
    step();
    sdreaddatavalid = 1'b0; sdreaddata = '0;
    @(negedge clk);
    check("crd_ret_vld", 64'(rd_valid), 64'd1);
    check("crd_ret_dat", 64'(rd_data), 64'hA5A50001);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      got = rd_ack;
      if (got) begin
        check("crd_addr17", 64'(sdaddress), 64'h000140);
        acks++;
      end
      step();
      if (got) rd_req = 1'b0;
      @(negedge clk);
    end
    check("crd_one_more", 64'(acks), 64'd1);
    check("crd_out_again", 64'(rd_outstanding), 64'd16);
    step();
    drain(16, 32'h10000000);

    // Quota fairness: last grant was RD, so writes lead: W8 R8 W8 R8.
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = 24'h000200; wr_addr = 24'h000300; wr_data = 32'hCAFE0000;
    nops = 0; both = 0;
    for (int c = 0; c < 60 && nops < 32; c++) begin
      @(negedge clk);
      if (sdread && sdwrite) both++;
      if (sdread || sdwrite) begin
        exp_op = (((nops / 8) % 2) == 0) ? 2'b01 : 2'b10;
        check("fair_op", {62'd0, sdread, sdwrite}, 64'(exp_op));
        check("fair_ack", {62'd0, rd_ack, wr_ack}, 64'(exp_op));
        if (nops == 0) check("fair_wbus", {8'd0, sdaddress, sdwritedata}, {8'd0, 24'h000300, 32'hCAFE0000});
        nops++;
      end
      if (nops < 32) step();
    end
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    check("fair_nops", 64'(nops), 64'd32);
    check("fair_never_both", 64'(both), 64'd0);
    @(negedge clk);
    check("fair_out", 64'(rd_outstanding), 64'd16);
    step();
    drain(16, 32'h20000000);

    // Hold rule: 8th read stalls 5 cycles at quota with a write waiting.
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = 24'h000400; wr_addr = 24'h000500; wr_data = 32'h12345678;
    acks = 0;
    for (int c = 0; c < 30 && acks < 7; c++) begin
      @(negedge clk);
      got = rd_ack;
      if (got) acks++;
      step();
      if (got) rd_addr = 24'h000400 + 24'(4 * acks);
    end
    sdwaitrequest = 1'b1;
    check("hold_acks7", 64'(acks), 64'd7);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_sdread", {62'd0, sdread, sdwrite}, 64'b10);
      check("hold_addr", 64'(sdaddress), 64'h00041C);
      check("hold_noack", 64'(rd_ack), 64'd0);
      step();
    end
    sdwaitrequest = 1'b0;
    @(negedge clk);
    check("hold_accept", {62'd0, rd_ack, sdread}, 64'b11);
    step();
    rd_req = 1'b0;
    @(negedge clk);
    check("hold_wr_next", {61'd0, sdread, sdwrite, wr_ack}, 64'b011);
    check("hold_wr_bus", {8'd0, sdaddress, sdwritedata}, {8'd0, 24'h000500, 32'h12345678});
    step();
    wr_req = 1'b0;
    check("hold_out", 64'(rd_outstanding), 64'd8);
    drain(8, 32'h30000000);

    // Simultaneous events at and just below the credit limit.
    rd_req = 1'b1; rd_addr = 24'h000600; acks = 0;
    for (int c = 0; c < 40 && acks < 16; c++) begin
      @(negedge clk);
      if (rd_ack) acks++;
      if (acks < 16) step();
    end
    step();
    sdreaddatavalid = 1'b1; sdreaddata = 32'hD1D1D1D1;
    @(negedge clk);
    check("sim_refuse", {62'd0, rd_ack, sdread}, 64'd0);
    check("sim_out16", 64'(rd_outstanding), 64'd16);
    step();
    sdreaddatavalid = 1'b0; sdreaddata = '0;
    @(negedge clk);
    check("sim_ret1", {31'd0, rd_valid, rd_data}, {31'd0, 1'b1, 32'hD1D1D1D1});
    check("sim_out15", 64'(rd_outstanding), 64'd15);
    step();
    sdreaddatavalid = 1'b1; sdreaddata = 32'hD2D2D2D2;
    @(negedge clk);
    check("sim_acc_ret", 64'(rd_ack), 64'd1);
    step();
    sdreaddatavalid = 1'b0; sdreaddata = '0; rd_req = 1'b0;
    @(negedge clk);
    check("sim_out_hold", 64'(rd_outstanding), 64'd15);
    check("sim_ret2", {31'd0, rd_valid, rd_data}, {31'd0, 1'b1, 32'hD2D2D2D2});
    step();
    drain(15, 32'h40000000);

`ifdef SDARB_STATS_EN
    check("stat_rd", 64'(stat_rd_count), 64'd58);
    check("stat_wr", 64'(stat_wr_count), 64'd17);
    check("stat_wait", 64'(stat_wait_cycles), 64'd5);
`else
    check("stat_off", {32'd0, stat_rd_count | stat_wr_count | stat_wait_cycles}, 64'd0);
`endif

    // Mid-op reset with 5 outstanding and a read held by waitrequest.
    rd_req = 1'b1; rd_addr = 24'h000700; acks = 0;
    for (int c = 0; c < 30 && acks < 5; c++) begin
      @(negedge clk);
      if (rd_ack) acks++;
      if (acks < 5) step();
    end
    step();
    sdwaitrequest = 1'b1;
    @(negedge clk);
    check("mid_out5", 64'(rd_outstanding), 64'd5);
    check("mid_pending", 64'(sdread), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_async_cmd", {38'd0, sdread, sdwrite, sdaddress}, 64'd0);
    check("mid_async_out", {56'd0, rd_ack, idle, err_unexpected, rd_outstanding}, 64'd0);
    rd_req = 1'b0; sdwaitrequest = 1'b0;
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("mid_rel", {61'd0, idle, err_unexpected, rd_valid}, 64'b100);
    check("mid_stats_clr", {32'd0, stat_rd_count | stat_wr_count | stat_wait_cycles}, 64'd0);
    sdreaddatavalid = 1'b1; sdreaddata = 32'hBAD0BAD0;
    step();
    sdreaddatavalid = 1'b0; sdreaddata = '0;
    @(negedge clk);
    check("stray_err", 64'(err_unexpected), 64'd1);
    check("stray_novld", 64'(rd_valid), 64'd0);
    check("stray_out0", 64'(rd_outstanding), 64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
